// File: rtl/xgmii_tx_framer.sv
// XGMII transmit framer: wraps a 64-bit packet stream with Start/preamble/SFD,
// Terminate, idle fill and the minimum inter-frame gap; underruns emit an error column.
module xgmii_tx_framer #(
  parameter int MIN_IFG = 12
) (
  input  logic        clk_i,
  input  logic        areset_n_i,
  input  logic [63:0] s_tdata_i,
  input  logic [7:0]  s_tkeep_i,
  input  logic        s_tvalid_i,
  input  logic        s_tlast_i,
  output logic        s_tready_o,
  output logic [63:0] xgmii_txd_o,
  output logic [7:0]  xgmii_txc_o,
  output logic        underrun_o
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_DATA     = 3'd2;
  localparam logic [2:0] ST_TERM     = 3'd3;
  localparam logic [2:0] ST_DROP     = 3'd4;
  localparam logic [2:0] ST_IFG      = 3'd5;

  localparam logic [63:0] COL_IDLE  = 64'h0707070707070707;
  localparam logic [63:0] COL_ERROR = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [63:0] COL_START = 64'hD5555555555555FB;
  localparam logic [63:0] COL_TERM  = 64'h07070707070707FD;

  function automatic logic [3:0] lead_ones(input logic [7:0] keep);
    logic [3:0] n;
    logic       run;
    n   = 4'd0;
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (run && keep[i]) n = n + 4'd1;
      else run = 1'b0;
    end
    return n;
  endfunction

  // Idle columns needed to cover the remaining gap bytes, never negative.
  function automatic logic [3:0] gap_cols(input int bytes);
    if (bytes <= 0) return 4'd0;
    return 4'((bytes + 7) / 8);
  endfunction

  localparam logic [3:0] GAP_TERM = gap_cols(MIN_IFG - 8);
  localparam logic [3:0] GAP_DROP = gap_cols(MIN_IFG);

  logic [2:0]  state, state_nxt;
  logic [3:0]  gap_cnt, gap_cnt_nxt;
  logic [63:0] txd_nxt;
  logic [7:0]  txc_nxt;
  logic        err_nxt;
  logic        ready_nxt;
  logic [3:0]  m;
  logic [3:0]  gap_last;

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    txd_nxt     = COL_IDLE;
    txc_nxt     = 8'hFF;
    err_nxt     = 1'b0;
    m           = lead_ones(s_tkeep_i);
    gap_last    = gap_cols(MIN_IFG - 8 + int'(m));

    case (state)
      ST_IDLE: begin
        if (s_tvalid_i) state_nxt = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        txd_nxt   = COL_START;
        txc_nxt   = 8'h01;
        state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (!s_tvalid_i) begin
          txd_nxt   = COL_ERROR;
          err_nxt   = 1'b1;
          state_nxt = ST_DROP;
        end else if (!s_tlast_i || m == 4'd8) begin
          txd_nxt = s_tdata_i;
          txc_nxt = 8'h00;
          if (s_tlast_i) state_nxt = ST_TERM;
        end else begin
          // Terminate lands in the first lane after the last valid byte.
          for (int i = 0; i < 8; i++) begin
            if (4'(i) < m) begin
              txd_nxt[8*i +: 8] = s_tdata_i[8*i +: 8];
              txc_nxt[i]        = 1'b0;
            end else if (4'(i) == m) begin
              txd_nxt[8*i +: 8] = 8'hFD;
            end else begin
              txd_nxt[8*i +: 8] = 8'h07;
            end
          end
          if (gap_last == 4'd0) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt   = ST_IFG;
            gap_cnt_nxt = gap_last;
          end
        end
      end
      ST_TERM: begin
        txd_nxt = COL_TERM;
        if (GAP_TERM == 4'd0) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt   = ST_IFG;
          gap_cnt_nxt = GAP_TERM;
        end
      end
      ST_DROP: begin
        if (s_tvalid_i && s_tlast_i) begin
          if (GAP_DROP == 4'd0) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt   = ST_IFG;
            gap_cnt_nxt = GAP_DROP;
          end
        end
      end
      ST_IFG: begin
        if (gap_cnt <= 4'd1) state_nxt = ST_IDLE;
        else gap_cnt_nxt = gap_cnt - 4'd1;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    ready_nxt = (state_nxt == ST_DATA) || (state_nxt == ST_DROP);
  end

  // Output register stage: everything the PHY and the source see is flopped here.
  always_ff @(posedge clk_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      state       <= ST_IDLE;
      gap_cnt     <= 4'd0;
      s_tready_o  <= 1'b0;
      xgmii_txd_o <= COL_IDLE;
      xgmii_txc_o <= 8'hFF;
      underrun_o  <= 1'b0;
    end else begin
      state       <= state_nxt;
      gap_cnt     <= gap_cnt_nxt;
      s_tready_o  <= ready_nxt;
      xgmii_txd_o <= txd_nxt;
      xgmii_txc_o <= txc_nxt;
      underrun_o  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_xgmii_tx_framer.sv
// Bench for xgmii_tx_framer: frames are serialised into an expected wire byte
// stream (preamble + payload + terminate + idle gap) and compared column by column.
module tb_xgmii_tx_framer;

  localparam int MIN_IFG = 12;
  localparam logic [63:0] IDLE_COL = 64'h0707070707070707;
  localparam logic [63:0] ERR_COL  = 64'hFEFEFEFEFEFEFEFE;

  logic        clk;
  logic        areset_n;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [63:0] txd;
  logic [7:0]  txc;
  logic        underrun;

  xgmii_tx_framer #(.MIN_IFG(MIN_IFG)) dut (
    .clk_i       (clk),
    .areset_n_i  (areset_n),
    .s_tdata_i   (s_tdata),
    .s_tkeep_i   (s_tkeep),
    .s_tvalid_i  (s_tvalid),
    .s_tlast_i   (s_tlast),
    .s_tready_o  (s_tready),
    .xgmii_txd_o (txd),
    .xgmii_txc_o (txc),
    .underrun_o  (underrun)
  );

  int ncmp = 0;
  int nfail = 0;
  int prev_n = 0;
  int prev_off = 0;

  logic [63:0] cap_d[$];
  logic [7:0]  cap_c[$];
  logic        cap_u[$];
  logic [63:0] exp_d[$];
  logic [7:0]  exp_c[$];
  logic        exp_u[$];
  logic [7:0]  wb[$];
  logic        wc[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int gap_n(input int bytes);
    return (bytes <= 0) ? 0 : (bytes + 7) / 8;
  endfunction

  task automatic step(output bit acc);
    acc = s_tvalid && s_tready;
    @(posedge clk);
    #1;
    cap_d.push_back(txd);
    cap_c.push_back(txc);
    cap_u.push_back(underrun);
  endtask

  task automatic push_idle(input int count);
    for (int i = 0; i < count; i++) begin
      exp_d.push_back(IDLE_COL);
      exp_c.push_back(8'hFF);
      exp_u.push_back(1'b0);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input logic ctl);
    wb.push_back(b);
    wc.push_back(ctl);
  endtask

  task automatic flush_cols();
    logic [63:0] d;
    logic [7:0]  c;
    while (wb.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        d[8*i +: 8] = wb.pop_front();
        c[i]        = wc.pop_front();
      end
      exp_d.push_back(d);
      exp_c.push_back(c);
      exp_u.push_back(1'b0);
    end
  endtask

  task automatic drive_beat(input logic [63:0] data, input logic [7:0] keep, input logic last);
    bit acc;
    int budget;
    s_tvalid = 1'b1;
    s_tdata  = data;
    s_tkeep  = keep;
    s_tlast  = last;
    acc      = 1'b0;
    budget   = 0;
    while (!acc && budget < 64) begin
      step(acc);
      budget++;
    end
    chk("beat_accept", 64'(acc), 64'd1);
  endtask

  // len beats, last-beat keep lk, d idle cycles before tvalid, underrun after uj beats for ug cycles.
  task automatic send_frame(input int len, input logic [7:0] lk, input int d,
                            input int uj, input int ug, input bit first);
    logic [63:0] data[8];
    logic [7:0]  keep[8];
    int          m;
    int          tail;
    bit          acc;
    for (int b = 0; b < len; b++) begin
      data[b] = {$urandom, $urandom};
      keep[b] = (b == len - 1) ? lk : 8'($urandom);
    end
    push_idle(first ? d + 1 : imax(prev_n, d - prev_off) + 1);
    push_byte(8'hFB, 1'b1);
    for (int i = 0; i < 6; i++) push_byte(8'h55, 1'b0);
    push_byte(8'hD5, 1'b0);
    flush_cols();
    if (uj > 0) begin
      for (int b = 0; b < uj; b++)
        for (int i = 0; i < 8; i++) push_byte(data[b][8*i +: 8], 1'b0);
      flush_cols();
      exp_d.push_back(ERR_COL);
      exp_c.push_back(8'hFF);
      exp_u.push_back(1'b1);
      push_idle(ug - 1 + len - uj);
      prev_n   = gap_n(MIN_IFG);
      prev_off = 0;
    end else begin
      for (int b = 0; b < len - 1; b++)
        for (int i = 0; i < 8; i++) push_byte(data[b][8*i +: 8], 1'b0);
      m = 0;
      while (m < 8 && lk[m]) m++;
      for (int i = 0; i < m; i++) push_byte(data[len-1][8*i +: 8], 1'b0);
      push_byte(8'hFD, 1'b1);
      while ((wb.size() % 8) != 0) push_byte(8'h07, 1'b1);
      flush_cols();
      tail     = (m == 8) ? 8 : 8 - m;
      prev_n   = gap_n(MIN_IFG - tail);
      prev_off = (m == 8) ? 1 : 0;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    for (int i = 0; i < d; i++) step(acc);
    for (int b = 0; b < len; b++) begin
      if (uj > 0 && b == uj) begin
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        for (int i = 0; i < ug; i++) step(acc);
      end
      drive_beat(data[b], keep[b], b == len - 1);
    end
  endtask

  task automatic finish_segment(input string tag);
    bit acc;
    int n;
    int f0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    for (int i = 0; i < 8; i++) step(acc);
    push_idle(8 - prev_off);
    chk({tag, "_len"}, 64'(cap_d.size()), 64'(exp_d.size()));
    n = (cap_d.size() < exp_d.size()) ? cap_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      f0 = nfail;
      chk($sformatf("%s_txd[%0d]", tag, i), cap_d[i], exp_d[i]);
      chk($sformatf("%s_txc[%0d]", tag, i), 64'(cap_c[i]), 64'(exp_c[i]));
      chk($sformatf("%s_underrun[%0d]", tag, i), 64'(cap_u[i]), 64'(exp_u[i]));
      if (nfail != f0) break;
    end
    cap_d.delete(); cap_c.delete(); cap_u.delete();
    exp_d.delete(); exp_c.delete(); exp_u.delete();
    wb.delete(); wc.delete();
  endtask

  task automatic clear_capture();
    cap_d.delete(); cap_c.delete(); cap_u.delete();
  endtask

  initial begin
    logic [7:0] lk;
    int         len;
    int         uj;
    int         ug;
    bit         acc;

    areset_n = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_txd", txd, IDLE_COL);
    chk("reset_txc", 64'(txc), 64'hFF);
    chk("reset_tready", 64'(s_tready), 64'd0);
    chk("reset_underrun", 64'(underrun), 64'd0);
    #2 areset_n = 1'b1;

    // Directed frames: partial terminate, full-width terminate, lane-7 terminate,
    // underrun, back-to-back 64-byte frames, non-contiguous keep after a pause.
    send_frame(2, 8'h0F, 0, 0, 0, 1'b1);
    send_frame(1, 8'hFF, 0, 0, 0, 1'b0);
    send_frame(1, 8'h7F, 0, 0, 0, 1'b0);
    send_frame(6, 8'hFF, 0, 3, 1, 1'b0);
    for (int f = 0; f < 3; f++) send_frame(8, 8'hFF, 0, 0, 0, 1'b0);
    send_frame(3, 8'hB7, 2, 0, 0, 1'b0);
    send_frame(1, 8'h00, 5, 0, 0, 1'b0);
    finish_segment("directed");

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 8);
      case ($urandom_range(0, 3))
        0:       lk = 8'hFF;
        1:       lk = 8'hFF >> $urandom_range(0, 8);
        default: lk = 8'($urandom);
      endcase
      uj = 0;
      ug = 0;
      if (len >= 2 && $urandom_range(0, 5) == 0) begin
        uj = $urandom_range(1, len - 1);
        ug = $urandom_range(1, 3);
      end
      send_frame(len, lk, $urandom_range(0, 4), uj, ug, f == 0);
    end
    finish_segment("random");

    // Reset asserted mid-frame
    drive_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    drive_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    drive_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    drive_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    #2 areset_n = 1'b0;
    #1;
    chk("midreset_txd", txd, IDLE_COL);
    chk("midreset_txc", 64'(txc), 64'hFF);
    chk("midreset_tready", 64'(s_tready), 64'd0);
    chk("midreset_underrun", 64'(underrun), 64'd0);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    step(acc);
    step(acc);
    chk("midreset_hold_txd", txd, IDLE_COL);
    chk("midreset_hold_txc", 64'(txc), 64'hFF);
    #2 areset_n = 1'b1;
    clear_capture();

    send_frame(3, 8'h3F, 1, 0, 0, 1'b1);
    for (int f = 0; f < 4; f++)
      send_frame($urandom_range(1, 8), 8'($urandom), $urandom_range(0, 3), 0, 0, 1'b0);
    finish_segment("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
